// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with held grants and bubble-free handoff.
// Optional tenure timeout is enabled by defining ARB_TIMEOUT_EN (uses HOLD_MAX).
module rr_arb4 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       to
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic       to_q, to_d;
  logic [2:0] pickNew;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] others;
  logic [2:0] pickOther;
`endif

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arb4: HOLD_MAX must be in 2..255");
  end

  // Returns {found, index} of the first set bit of v, scanning base, base+1, ... with wrap.
  function automatic logic [2:0] pick(input logic [3:0] v, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] c;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      c = base + 2'(k);
      if (v[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    to_d    = 1'b0;
    pickNew = 3'b000;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = 8'd0;
    others    = req & ~(4'b0001 << idx_q);
    pickOther = pick(others, idx_q + 2'd1);
`endif
    case (state_q)
      IDLE: begin
        pickNew = pick(req, last_q + 2'd1);
        if (pickNew[2]) begin
          state_d = GRANT;
          idx_d   = pickNew[1:0];
          last_d  = pickNew[1:0];
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          pickNew = pick(req, idx_q + 2'd1);
          if (pickNew[2]) begin
            idx_d  = pickNew[1:0];
            last_d = pickNew[1:0];
          end else begin
            state_d = IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          // At the tenure limit, revoke only if someone else is waiting.
          if (cnt_q == 8'(HOLD_MAX - 1)) begin
            if (pickOther[2]) begin
              idx_d  = pickOther[1:0];
              last_d = pickOther[1:0];
              to_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'b00;
      last_q  <= 2'b11;
      gnt_q   <= 4'b0000;
      to_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = (state_q == GRANT);
  assign to      = to_q;

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter that shares one resource, such as a 2-to-4-decoded output bank or bus, among four clients. A registered 2-bit grant index drives a one-hot grant vector, equivalent to a 2-to-4 decoder enabled by `gnt_vld`. Grants are held until the owner releases. Ownership hands off to the next pending requester without a bubble cycle.

## Interface
- `HOLD_MAX`, default 15: maximum cycles of one grant tenure. Used only when `ARB_TIMEOUT_EN` is defined; legal range 2..255.
- `clk`  in  1  rising-edge clock, sole clock domain
- `rst`  in  1  synchronous, active-high reset
- `req`  in  4  request vector; `req[k]` high = client k wants or holds the resource
- `gnt`  out  4  one-hot grant; all zero when no grant
- `gnt_idx`  out  2  binary index of current owner; valid only when `gnt_vld`=1
- `gnt_vld`  out  1  a grant is active; equals OR of `gnt`
- `to`  out  1  one-cycle pulse: current grant forcibly revoked by timeout (constant 0 without macro)

## Operation
- State machine with two states:
  - IDLE: no grant.
  - GRANT: owner `gnt_idx` holds the resource.
- Round-robin pointer `last` (2 bits) = index of most recent owner. Search order starts at `last`+1 mod 4 and wraps: `last`+1, +2, +3, then `last` itself.
- IDLE, any `req` high -> GRANT. `gnt_idx` = first set bit in search order; `last` <= that index.
- IDLE, `req`=0 -> stay IDLE.
- GRANT, `req[gnt_idx]`=1 -> stay; outputs unchanged, except timeout with macro enabled.
- GRANT, `req[gnt_idx]`=0 and another bit set -> stay GRANT. New owner = first set bit searching from old `gnt_idx`+1. `last` updated. Direct handoff, no idle cycle.
- GRANT, `req[gnt_idx]`=0, no other bit set -> IDLE; `gnt`=0.
- `gnt` = one-hot decode of `gnt_idx` gated by `gnt_vld`. Bit k set iff `gnt_idx`=k and `gnt_vld`=1.
- Never more than one `gnt` bit set; never `gnt_vld`=1 with `gnt`=0.
- A requester dropping `req` while not granted is simply skipped; no request memory.

## Timing
- All outputs registered; no combinational path from `req` to `gnt`.
- Grant latency: `req` sampled high at edge N from IDLE -> `gnt` high after edge N. Minimum one cycle.
- Release latency: owner `req` sampled low at edge N -> that `gnt` bit low after edge N. Any handoff grant appears on the same edge.
- Owner holds at least one full cycle of `gnt` per tenure.
- Reset, including mid-tenure: after the `rst` edge, state=IDLE, `gnt`=0000, `gnt_idx`=00, `gnt_vld`=0, `to`=0, `last`=11 so client 0 has first priority, timeout counter=0. `rst` overrides all other inputs.
- Simultaneous release and new requests: resolved by search order above in one edge.
- Owner re-raising `req` the cycle after release competes normally; it has lowest priority if others are pending.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - 8-bit tenure counter cleared on every new grant (including handoff) and incremented each GRANT cycle.
  - When the counter reaches `HOLD_MAX`-1 and another requester is pending, the grant moves to the next requester in search order on that edge, even if the owner's `req` is still high. `to` pulses high for exactly the first cycle of the new grant.
  - If no other requester is pending, the counter clears and the owner keeps the grant; `to` stays 0.
- Not defined: no counter logic; grants are unbounded; `to` is tied 0; `HOLD_MAX` is ignored.

## Test plan
- Reset: hold `rst`=1 two cycles with `req`=1111 -> `gnt`=0000, `gnt_vld`=0, `gnt_idx`=00, `to`=0. Release `rst` -> next cycle `gnt`=0001.
- Rotation: `req`=1111 with each owner dropping its `req` for one cycle after 3 cycles of tenure -> grant order 0001, 0010, 0100, 1000, 0001, with no bubble cycles.
- Skip and wrap: `last`=2, `req`=0011 -> `gnt`=0001. Owner 0 releases -> `gnt`=0010.
- Idle return: sole owner 2 drops `req` -> `gnt`=0000, `gnt_vld`=0 next cycle. `req`=0100 again -> `gnt`=0100 one cycle later.
- Mid-tenure reset: owner 3 active, pulse `rst` one cycle -> `gnt`=0000. With `req`=1001, next grant is 0001.
- Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX`=4): `req`=0011 held -> `gnt`=0001 for 4 cycles, then 0010 with `to`=1 for one cycle. With `req`=0001 only, grant holds indefinitely and `to` stays 0.
